des_final_perm: RTL
===================

Name: des_final_perm

Overview:
- Output stage of the DES datapath. Consumes L16/R16 after the 16th round of the key-schedule/round loop.
- Forms the pre-output block by swapping the halves, then applies the DES final permutation (FP = IP^-1) one bit per cycle from an internal 64x6 table ROM.
- Presents the 64-bit ciphertext on a held return register using the same ap_start/ap_done/ap_idle/ap_ready block-level handshake as the top_function core.

Parameters:
- NO_SWAP, 0, 0: pre-output = {R, L} (standard DES). 1: pre-output = {L, R} (test/debug only).
- ROM_LATENCY, 1, table ROM read latency in cycles. Only 1 is supported; any other value is a synthesis error.

Ports:
- ap_clk  input  1  clock, all state changes on rising edge
- ap_rst  input  1  asynchronous, active-high reset
- ap_start  input  1  start request, sampled in IDLE
- ap_done  output  1  one-cycle pulse, result valid
- ap_idle  output  1  high in IDLE while ap_start=0
- ap_ready  output  1  equal to ap_done; inputs may change after this
- L  input  32  round-16 left half, sampled on start accept
- R  input  32  round-16 right half, sampled on start accept
- ap_return  output  64  ciphertext, held until the next start accept

Behaviour:
- Bit numbering follows DES convention: bit 1 = MSB (bit 63). FP[i] is the source pre-output bit for output bit i.
- FP table rows: 40 8 48 16 56 24 64 32 / 39 7 47 15 55 23 63 31 / 38 6 46 14 54 22 62 30 / 37 5 45 13 53 21 61 29 / 36 4 44 12 52 20 60 28 / 35 3 43 11 51 19 59 27 / 34 2 42 10 50 18 58 26 / 33 1 41 9 49 17 57 25.
- ROM stores 64 - FP[i] (LSB index, 6 bits). Read is registered, with ce asserted only in RUN.
- States are one-hot: IDLE, RUN, DRAIN, DONE.
- IDLE: when ap_start=1, latch pre-output into a 64-bit src register, clear the 7-bit address counter, clear the shift accumulator, go to RUN.
- RUN: issue ROM address = counter, counter += 1. From the second RUN cycle on, shift acc left by 1 and insert src >> rom_q (bit 0). Leave RUN when counter reaches 63 after issuing it, going to DRAIN.
- DRAIN: insert the final bit, load ap_return <= completed acc, go to DONE.
- DONE: ap_done=ap_ready=1 for exactly this cycle, then go to IDLE.
- Latency: start-accept edge to ap_done high is exactly 66 cycles (64 RUN + DRAIN + DONE). No overlap: next start is accepted in IDLE only, and ap_start is ignored in RUN/DRAIN/DONE.
- ap_start held high continuously: back-to-back operations with one IDLE cycle between runs. ap_idle stays 0 throughout.
- L/R changing after start accept has no effect on the current run.
- Reset values (asynchronous, any state including mid-RUN): state=IDLE, ap_return=0, counter=0, acc=0, src=0, ap_done=ap_ready=0. ap_idle=1 after reset when ap_start=0.
- ap_return changes only in DRAIN. Between runs it holds the last ciphertext.
- Counter wrap: the counter is 7 bits. Values 64..127 are never reached. Any illegal one-hot state code returns to IDLE on the next edge.

Test Plan:
- Reset then ap_start=0 for 10 cycles -> ap_idle=1, ap_done=0, ap_return=0.
- L=0x43423234, R=0x0A4CD995, start pulse -> ap_done exactly 66 cycles after accept, ap_return=0x85E813540F0AB405 (textbook DES vector, key 133457799BBCDFF1, pt 0123456789ABCDEF).
- L=0x00000000, R=0x80000000 -> ap_return=0x0000000000000040. Repeat with all-zero inputs -> 0, all-ones inputs -> 0xFFFFFFFFFFFFFFFF.
- ap_start tied high with two vectors changed at ap_ready -> two ap_done pulses 67 cycles apart, correct results each. Also verify ap_return is held between the pulses.
- Assert ap_rst at cycle 30 of RUN -> outputs drop to reset values immediately (before the next clock edge). A fresh start then completes normally with the correct result.
- Random sweep: 1000 vectors versus a reference model computing FP({R,L}). Also check IP(ap_return) == {R,L}.

Source files
------------

// File: rtl/des_final_perm.sv
// DES output stage: swaps the round-16 halves and applies the final
// permutation one bit per cycle from a 64-entry table ROM.
module des_final_perm #(
    parameter int NO_SWAP     = 0,
    parameter int ROM_LATENCY = 1
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] L,
    input  logic [31:0] R,
    output logic [63:0] ap_return
);

    // The datapath is built around a single registered ROM stage.
    if (ROM_LATENCY != 1) begin : g_bad_latency
        $error("des_final_perm: only ROM_LATENCY=1 is supported");
    end

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    // LSB index of the source bit for each output bit, MSB output first.
    localparam logic [5:0] FP_ROM [64] = '{
        6'd24, 6'd56, 6'd16, 6'd48, 6'd8,  6'd40, 6'd0, 6'd32,
        6'd25, 6'd57, 6'd17, 6'd49, 6'd9,  6'd41, 6'd1, 6'd33,
        6'd26, 6'd58, 6'd18, 6'd50, 6'd10, 6'd42, 6'd2, 6'd34,
        6'd27, 6'd59, 6'd19, 6'd51, 6'd11, 6'd43, 6'd3, 6'd35,
        6'd28, 6'd60, 6'd20, 6'd52, 6'd12, 6'd44, 6'd4, 6'd36,
        6'd29, 6'd61, 6'd21, 6'd53, 6'd13, 6'd45, 6'd5, 6'd37,
        6'd30, 6'd62, 6'd22, 6'd54, 6'd14, 6'd46, 6'd6, 6'd38,
        6'd31, 6'd63, 6'd23, 6'd55, 6'd15, 6'd47, 6'd7, 6'd39
    };

    state_t      state_q, state_d;
    logic [63:0] src_q, src_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] ret_q, ret_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [5:0]  rom_q, rom_d;
    logic        done_q, done_d;
    logic [63:0] pre_out;
    logic        rom_ce;

    // Pre-output block: halves swapped unless the debug bypass is set.
    assign pre_out = (NO_SWAP != 0) ? {L, R} : {R, L};
    assign rom_ce  = (state_q == S_RUN);

    // Registered table read, enabled only while addresses are issued.
    always_comb begin
        rom_d = rom_q;
        if (rom_ce) begin
            rom_d = FP_ROM[cnt_q[5:0]];
        end
    end

    // Sequencer and shift datapath next-state logic.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        acc_d   = acc_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    src_d   = pre_out;
                    cnt_d   = 7'd0;
                    acc_d   = 64'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // ROM data lags the address by one cycle, so the
                // first RUN cycle has nothing to insert yet.
                if (cnt_q != 7'd0) begin
                    acc_d = {acc_q[62:0], src_q[rom_q]};
                end
                if (cnt_q == 7'd63) begin
                    cnt_d   = 7'd0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_DRAIN: begin
                acc_d   = {acc_q[62:0], src_q[rom_q]};
                ret_d   = acc_d;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign done_d = (state_d == S_DONE);

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            src_q   <= 64'd0;
            acc_q   <= 64'd0;
            ret_q   <= 64'd0;
            cnt_q   <= 7'd0;
            rom_q   <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            acc_q   <= acc_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            rom_q   <= rom_d;
            done_q  <= done_d;
        end
    end

    assign ap_done   = done_q;
    assign ap_ready  = done_q;
    assign ap_idle   = (state_q == S_IDLE) && !ap_start;
    assign ap_return = ret_q;

endmodule
